timer_irq_master: RTL
=====================

Name: timer_irq_master

Overview:
- Avalon-MM master that services an interval-timer slave with a 16-bit data path and 3-bit word addressing.
- Registers map as follows: 0 = status, 1 = control, 4/5 = snapshot lo/hi.
- After reset and when enabled, it programs the timer's interrupt enable, then waits for irq. On each irq it clears the timeout, takes a counter snapshot and reads it back, presenting a tick pulse, a tick count and the 32-bit snapshot to fabric logic.
- Sits beside the timer on the same clock; no CPU is involved.

Parameters:
- TICK_W, 16, width of tick_count.
- READ_LATENCY, 1, fixed slave read latency in cycles from accepted read to valid readdata (1..3).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  level; 1 = service timer, 0 = quiesce.
- address  out  3  Avalon word address.
- chipselect  out  1  transfer request.
- write_n  out  1  0 = write, 1 = read (when chipselect=1).
- writedata  out  16  write data.
- readdata  in  16  slave read data.
- waitrequest  in  1  slave stall; tie 0 for zero-wait slaves.
- irq  in  1  timer interrupt, level.
- tick  out  1  one-cycle pulse per serviced interrupt.
- tick_count  out  TICK_W  serviced interrupts, wraps.
- snapshot  out  32  {hi,lo} snapshot readback.
- snapshot_valid  out  1  one-cycle pulse when snapshot updates.
- busy  out  1  1 whenever state is not IDLE or WAIT_IRQ.

Behaviour:
- Reset (asynchronous, reset_n=0): state=IDLE. chipselect=0, write_n=1, address=0, writedata=0, tick=0, tick_count=0, snapshot=0, snapshot_valid=0, busy=0.
- Bus rule: a transfer is accepted on the edge where chipselect=1 and waitrequest=0. address, write_n and writedata hold stable while waitrequest=1. chipselect=0 in all non-bus states.
- Read data capture: readdata is sampled exactly READ_LATENCY clocks after the accepting edge. A latency counter counts down in the *_WAIT states; no new transfer is issued during the wait.
- FSM states and transitions:
  - IDLE: when enable=1, go to INIT.
  - INIT: write addr1 data 0x0001; on accept go to WAIT_IRQ.
  - WAIT_IRQ: if enable=0, go to STOP. Else if irq=1, go to CLR. enable=0 wins if both occur in the same cycle.
  - CLR: write addr0 data 0x0000. On accept, go to SNAP; tick pulses in the following cycle and tick_count increments on the same edge.
  - SNAP: write addr4 data 0x0000; on accept go to RD_LO.
  - RD_LO: read addr4; on accept go to RD_LO_WAIT.
  - RD_LO_WAIT: after READ_LATENCY edges, latch readdata into snapshot[15:0] and go to RD_HI.
  - RD_HI: read addr5; on accept go to RD_HI_WAIT.
  - RD_HI_WAIT: after READ_LATENCY edges, latch readdata into snapshot[31:16] and go to WAIT_IRQ. snapshot_valid pulses in the cycle after the hi latch.
  - STOP: write addr1 data 0x0000; on accept go to IDLE.
- Service sequence: enable is ignored mid-sequence (CLR through RD_HI_WAIT); it is re-checked only in WAIT_IRQ.
- Write-to-irq latency: the irq level seen in WAIT_IRQ is trusted only after a write to addr0 has had ≥2 cycles to propagate. The service sequence guarantees this.
- Back-to-back interrupts: an irq that reasserts during servicing is handled on the return to WAIT_IRQ. Events are never queued beyond the level.
- Wrap: tick_count rolls over from all-ones to 0 with no flag.
- Minimum service time with waitrequest=0 and READ_LATENCY=1: 7 cycles from the WAIT_IRQ edge that sees irq to the return to WAIT_IRQ.
- Reset mid-transfer: all outputs return to reset values immediately. There is no partial snapshot update.

Test Plan:
- Reset then enable=1, waitrequest=0 -> first transfer is a write to addr1 with data 0x0001 on the second cycle after enable; FSM then enters WAIT_IRQ with busy=0.
- Model slave with irq pulsed, snapshot=0x0007A11F, READ_LATENCY=1 -> bus writes addr0, then addr4, then reads addr4 and addr5. snapshot=0x0007A11F, snapshot_valid pulses once, tick pulses once, tick_count=1.
- waitrequest held 3 cycles on each transfer -> address, write_n and writedata stable throughout; final snapshot value identical to the no-stall run; no extra transfers.
- READ_LATENCY=3 with slave returning 0x1234 then 0x0005 -> snapshot=0x00051234 and no read issued during wait cycles.
- TICK_W=4, 17 interrupts -> tick_count=1 after wrap and exactly 17 tick pulses.
- enable dropped while in WAIT_IRQ with irq rising the same cycle -> write addr1 data 0x0000, return to IDLE, no tick. Separately, reset_n asserted during RD_HI_WAIT -> snapshot=0 and chipselect=0 immediately.

Source files
------------

// File: rtl/timer_irq_master.sv
// Avalon-MM master that arms an interval timer, services its interrupt and
// reads back a 32-bit counter snapshot, presenting tick/count/snapshot to fabric.
module timer_irq_master #(
    parameter int TICK_W       = 16,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    output logic [2:0]        address,
    output logic              chipselect,
    output logic              write_n,
    output logic [15:0]       writedata,
    input  logic [15:0]       readdata,
    input  logic              waitrequest,
    input  logic              irq,
    output logic              tick,
    output logic [TICK_W-1:0] tick_count,
    output logic [31:0]       snapshot,
    output logic              snapshot_valid,
    output logic              busy
);

    localparam logic [2:0]  ADDR_STATUS  = 3'd0;
    localparam logic [2:0]  ADDR_CONTROL = 3'd1;
    localparam logic [2:0]  ADDR_SNAP_LO = 3'd4;
    localparam logic [2:0]  ADDR_SNAP_HI = 3'd5;
    localparam logic [15:0] CTRL_ITO     = 16'h0001;
    // READ_LATENCY is limited to 1..3, so a 2-bit countdown suffices.
    localparam logic [1:0]  LAT_LOAD     = 2'(READ_LATENCY - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_INIT,
        S_WAIT_IRQ,
        S_CLR,
        S_SNAP,
        S_RD_LO,
        S_RD_LO_WAIT,
        S_RD_HI,
        S_RD_HI_WAIT,
        S_STOP
    } state_t;

    state_t      state, state_nxt;
    logic [1:0]  lat_cnt, lat_cnt_nxt;
    logic        tick_set;
    logic        lo_latch;
    logic        hi_latch;
    logic [15:0] snap_lo_p0;

    always_comb begin
        state_nxt   = state;
        lat_cnt_nxt = lat_cnt;
        chipselect  = 1'b0;
        write_n     = 1'b1;
        address     = ADDR_STATUS;
        writedata   = 16'h0000;
        tick_set    = 1'b0;
        lo_latch    = 1'b0;
        hi_latch    = 1'b0;

        case (state)
            S_IDLE: begin
                if (enable) state_nxt = S_INIT;
            end
            S_INIT: begin
                chipselect = 1'b1;
                write_n    = 1'b0;
                address    = ADDR_CONTROL;
                writedata  = CTRL_ITO;
                if (!waitrequest) state_nxt = S_WAIT_IRQ;
            end
            S_WAIT_IRQ: begin
                // Quiescing takes priority over a coincident interrupt.
                if (!enable)  state_nxt = S_STOP;
                else if (irq) state_nxt = S_CLR;
            end
            S_CLR: begin
                chipselect = 1'b1;
                write_n    = 1'b0;
                address    = ADDR_STATUS;
                if (!waitrequest) begin
                    state_nxt = S_SNAP;
                    tick_set  = 1'b1;
                end
            end
            S_SNAP: begin
                chipselect = 1'b1;
                write_n    = 1'b0;
                address    = ADDR_SNAP_LO;
                if (!waitrequest) state_nxt = S_RD_LO;
            end
            S_RD_LO: begin
                chipselect = 1'b1;
                address    = ADDR_SNAP_LO;
                if (!waitrequest) begin
                    state_nxt   = S_RD_LO_WAIT;
                    lat_cnt_nxt = LAT_LOAD;
                end
            end
            S_RD_LO_WAIT: begin
                if (lat_cnt == 2'd0) begin
                    lo_latch  = 1'b1;
                    state_nxt = S_RD_HI;
                end else begin
                    lat_cnt_nxt = lat_cnt - 2'd1;
                end
            end
            S_RD_HI: begin
                chipselect = 1'b1;
                address    = ADDR_SNAP_HI;
                if (!waitrequest) begin
                    state_nxt   = S_RD_HI_WAIT;
                    lat_cnt_nxt = LAT_LOAD;
                end
            end
            S_RD_HI_WAIT: begin
                if (lat_cnt == 2'd0) begin
                    hi_latch  = 1'b1;
                    state_nxt = S_WAIT_IRQ;
                end else begin
                    lat_cnt_nxt = lat_cnt - 2'd1;
                end
            end
            S_STOP: begin
                chipselect = 1'b1;
                write_n    = 1'b0;
                address    = ADDR_CONTROL;
                if (!waitrequest) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign busy = (state != S_IDLE) && (state != S_WAIT_IRQ);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            lat_cnt        <= 2'd0;
            tick           <= 1'b0;
            tick_count     <= '0;
            snapshot       <= 32'h0000_0000;
            snapshot_valid <= 1'b0;
        end else begin
            state          <= state_nxt;
            lat_cnt        <= lat_cnt_nxt;
            tick           <= tick_set;
            snapshot_valid <= hi_latch;
            if (tick_set) tick_count <= tick_count + TICK_W'(1);
            // Both halves land together so fabric never sees a torn value.
            if (hi_latch) snapshot <= {readdata, snap_lo_p0};
        end
    end

    // Low half is held until the high half arrives.
    always_ff @(posedge clk) begin
        if (lo_latch) snap_lo_p0 <= readdata;
    end

endmodule
